// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared state encoding and default widths for the PWM fade sequencer
package pwm_pkg;

    localparam int COMPARE_SIZE_DEF  = 8;
    localparam int INTERVAL_SIZE_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        WRITE = 2'd2,
        GAP   = 2'd3
    } fade_state_e;

endpackage

// File: rtl/pwm_gamma_map.sv
// rtl/pwm_gamma_map.sv - combinational square-law level to compare mapping
module pwm_gamma_map
    import pwm_pkg::*;
#(
    parameter int COMPARE_SIZE = COMPARE_SIZE_DEF
) (
    input  logic [COMPARE_SIZE-1:0] level_i,
    output logic [COMPARE_SIZE-1:0] compare_o
);

    logic [2*COMPARE_SIZE-1:0] level_w;

    assign level_w = {{COMPARE_SIZE{1'b0}}, level_i};

    // Full scale maps to full scale so 100% duty stays reachable after squaring.
    assign compare_o = (&level_i) ? {COMPARE_SIZE{1'b1}}
                                  : COMPARE_SIZE'((level_w * level_w) >> COMPARE_SIZE);

endmodule

// File: rtl/pwm_fade_sequencer.sv
// rtl/pwm_fade_sequencer.sv - ramps a PWM compare level toward a target with spaced write strobes
// Optional gamma mapping of compare_out enabled by PWM_FADE_GAMMA_EN.
module pwm_fade_sequencer
    import pwm_pkg::*;
#(
    parameter int COMPARE_SIZE  = COMPARE_SIZE_DEF,
    parameter int INTERVAL_SIZE = INTERVAL_SIZE_DEF
) (
    input  logic                     sys_clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic [COMPARE_SIZE-1:0]  target_in,
    input  logic [COMPARE_SIZE-1:0]  step_in,
    input  logic [INTERVAL_SIZE-1:0] interval_in,
    output logic [COMPARE_SIZE-1:0]  compare_out,
    output logic                     wr_out,
    output logic                     busy,
    output logic                     done
);

    fade_state_e              state_q;
    logic [COMPARE_SIZE-1:0]  level_q, target_q, step_q, compare_q;
    logic [INTERVAL_SIZE-1:0] interval_q, cnt_q;
    logic                     dir_up_q, wr_q, busy_q, done_q;

    logic [COMPARE_SIZE:0]    sum_d, diff_d;
    logic [COMPARE_SIZE-1:0]  level_d, compare_d, step_eff;
    logic [INTERVAL_SIZE-1:0] interval_eff;

    assign step_eff     = (step_in == '0) ? COMPARE_SIZE'(1) : step_in;
    assign interval_eff = (interval_in == '0) ? INTERVAL_SIZE'(1) : interval_in;

    // One extra bit catches both overflow and borrow; either way the result clamps to target.
    always_comb begin
        sum_d   = {1'b0, level_q} + {1'b0, step_q};
        diff_d  = {1'b0, level_q} - {1'b0, step_q};
        level_d = target_q;
        if (dir_up_q) begin
            if (sum_d < {1'b0, target_q}) level_d = sum_d[COMPARE_SIZE-1:0];
        end else if (!diff_d[COMPARE_SIZE] && (diff_d[COMPARE_SIZE-1:0] > target_q)) begin
            level_d = diff_d[COMPARE_SIZE-1:0];
        end
    end

`ifdef PWM_FADE_GAMMA_EN
    pwm_gamma_map #(
        .COMPARE_SIZE(COMPARE_SIZE)
    ) u_gamma (
        .level_i  (level_d),
        .compare_o(compare_d)
    );
`else
    assign compare_d = level_d;
`endif

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            level_q    <= '0;
            target_q   <= '0;
            step_q     <= '0;
            interval_q <= '0;
            cnt_q      <= '0;
            compare_q  <= '0;
            dir_up_q   <= 1'b0;
            wr_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            wr_q   <= 1'b0;
            done_q <= 1'b0;
            if (abort) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start) begin
                            target_q   <= target_in;
                            step_q     <= step_eff;
                            interval_q <= interval_eff;
                            if (level_q == target_in) begin
                                done_q <= 1'b1;
                            end else begin
                                dir_up_q <= (target_in > level_q);
                                cnt_q    <= interval_eff - INTERVAL_SIZE'(1);
                                state_q  <= WAIT;
                                busy_q   <= 1'b1;
                            end
                        end
                    end
                    WAIT: begin
                        if (cnt_q == '0) begin
                            level_q   <= level_d;
                            compare_q <= compare_d;
                            wr_q      <= 1'b1;
                            state_q   <= WRITE;
                        end else begin
                            cnt_q <= cnt_q - INTERVAL_SIZE'(1);
                        end
                    end
                    WRITE: state_q <= GAP;
                    GAP: begin
                        if (level_q == target_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q   <= interval_q - INTERVAL_SIZE'(1);
                            state_q <= WAIT;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign compare_out = compare_q;
    assign wr_out      = wr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
// tb/tb_pwm_fade_sequencer.sv - scoreboard bench for pwm_fade_sequencer
module tb_pwm_fade_sequencer;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [7:0]  target_in = '0;
    logic [7:0]  step_in = '0;
    logic [15:0] interval_in = '0;
    logic [7:0]  compare_out;
    logic        wr_out, busy, done;

    typedef struct {
        int cyc;
        int val;
    } wr_t;

    wr_t  wq[$];
    int   dq[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   model_level = 0;
    logic wr_prev = 1'b0;
    logic [7:0] cmp_prev = '0;

    pwm_fade_sequencer #(
        .COMPARE_SIZE(8),
        .INTERVAL_SIZE(16)
    ) dut (
        .sys_clk    (sys_clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .target_in  (target_in),
        .step_in    (step_in),
        .interval_in(interval_in),
        .compare_out(compare_out),
        .wr_out     (wr_out),
        .busy       (busy),
        .done       (done)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int gmap(input int l);
`ifdef PWM_FADE_GAMMA_EN
        return (l == 255) ? 255 : (l * l) >> 8;
`else
        return l;
`endif
    endfunction

    task automatic push_fade(input int tgt, input int s, input int i, input int k, input int maxw);
        int lvl = model_level;
        int n = 0;
        while (lvl != tgt && n < maxw) begin
            if (tgt > lvl) lvl = (lvl + s > tgt) ? tgt : lvl + s;
            else           lvl = (lvl - s < tgt) ? tgt : lvl - s;
            n++;
            wq.push_back('{k + i + (n - 1) * (i + 2), gmap(lvl)});
        end
        if (lvl == tgt) dq.push_back(k + n * (i + 2));
        model_level = lvl;
    endtask

    task automatic start_fade(input int tgt, input int s, input int i, input int maxw);
        @(negedge sys_clk);
        target_in   = 8'(tgt);
        step_in     = 8'(s);
        interval_in = 16'(i);
        start       = 1'b1;
        push_fade(tgt, (s == 0) ? 1 : s, (i == 0) ? 1 : i, cyc + 1, maxw);
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || wq.size() != 0 || dq.size() != 0) && n < 2000) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check("idle_timeout", int'(n < 2000), 1);
    endtask

    task automatic wait_wr();
        int n = 0;
        while (wq.size() != 0 && n < 500) begin
            @(negedge sys_clk);
            #1;
            n++;
        end
        check("wr_timeout", int'(n < 500), 1);
    endtask

    // Scoreboard: pops expected writes and done pulses as the DUT produces them.
    always @(negedge sys_clk) begin
        if (!rst) begin
            if (wr_out) begin
                check("wr_consecutive", int'(wr_prev), 0);
                if (wq.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    wr_t e;
                    e = wq.pop_front();
                    check("wr_value", int'(compare_out), e.val);
                    check("wr_cycle", cyc, e.cyc);
                end
            end else if (compare_out != cmp_prev) begin
                check("compare_without_wr", int'(compare_out), int'(cmp_prev));
            end
            if (done) begin
                if (dq.size() == 0) check("done_unexpected", 1, 0);
                else                check("done_cycle", cyc, dq.pop_front());
            end
        end
        wr_prev  = wr_out;
        cmp_prev = compare_out;
    end

    initial begin
        repeat (2) @(negedge sys_clk);
        check("rst_compare", int'(compare_out), 0);
        check("rst_wr", int'(wr_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        #1 rst = 1'b0;

        start_fade(10, 4, 3, 99);
        wait_idle();
        start_fade(1, 4, 1, 99);
        wait_idle();

        start_fade(1, 7, 2, 99);
        #1 check("equal_busy", int'(busy), 0);
        wait_idle();

        start_fade(3, 0, 0, 99);
        wait_idle();
        start_fade(0, 0, 0, 99);
        wait_idle();

        start_fade(100, 4, 5, 1);
        wait_wr();
        repeat (2) @(negedge sys_clk);
        abort = 1'b1;
        @(negedge sys_clk);
        abort = 1'b0;
        #1;
        check("abort_busy", int'(busy), 0);
        check("abort_wr", int'(wr_out), 0);
        check("abort_hold", int'(compare_out), 4);
        repeat (20) @(negedge sys_clk);
        check("abort_no_done", dq.size(), 0);

        @(negedge sys_clk);
        start = 1'b1;
        abort = 1'b1;
        target_in = 8'd50;
        @(negedge sys_clk);
        start = 1'b0;
        abort = 1'b0;
        #1 check("start_abort_busy", int'(busy), 0);
        repeat (10) @(negedge sys_clk);
        check("start_abort_level", int'(compare_out), 4);

        start_fade(20, 8, 2, 99);
        repeat (2) @(negedge sys_clk);
        start = 1'b1;
        target_in = 8'd0;
        step_in = 8'd1;
        interval_in = 16'd0;
        repeat (2) @(negedge sys_clk);
        start = 1'b0;
        wait_idle();
        check("busy_start_final", int'(compare_out), 20);

        start_fade(100, 10, 6, 1);
        wait_wr();
        repeat (2) @(negedge sys_clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_compare", int'(compare_out), 0);
        check("midrst_wr", int'(wr_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        wq.delete();
        dq.delete();
        model_level = 0;
        repeat (2) @(negedge sys_clk);
        #1 rst = 1'b0;

        start_fade(255, 128, 2, 99);
        wait_idle();
        check("gamma_final", int'(compare_out), 255);

        repeat (3) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
